// File: rtl/icache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// icache_miss_ctrl
// Miss sequencer for a pipelined, direct-mapped, read-only instruction cache.
// Compares the tag/valid read back from the arrays with the request address,
// stalls on a miss, fetches the 256-bit line from physical memory, pulses the
// array write enables for one cycle, replays the request, and keeps saturating
// hit/miss counters.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_addr : request in the array stage (set [8:5], tag [31:9])
//   tag_i/valid_i      : tag and valid bit read for the current set
//   pmem_resp          : memory has returned the line (only honoured in FETCH)
//   pmem_read          : line read request to memory
//   pmem_address       : line-aligned fetch address latched at the miss
//   data/tag/valid_web : array write enables, one-cycle pulse in ALLOC
//   stall              : freezes upstream pipeline and array selection
//   mem_resp           : request hit this cycle
//   hit_count          : CHECK cycles with a hit, saturating
//   miss_count         : CHECK->FETCH transitions, saturating
// ----------------------------------------------------------------------------
module icache_miss_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  logic [23:0]      tag_i,
    input  logic             valid_i,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic [31:0]      pmem_address,
    output logic             data_web,
    output logic             tag_web,
    output logic             valid_web,
    output logic             stall,
    output logic             mem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned      ADDR_W  = 32;
    localparam int unsigned      OFF_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_CHECK,
        ST_FETCH,
        ST_ALLOC,
        ST_REPLAY
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pmem_addr_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [CNT_W-1:0]   miss_cnt_q;

    logic               hit;
    logic               hit_evt;
    logic               miss_evt;
    logic               unused_bits;

    // Line offset and the spare top tag bit take no part in the lookup.
    assign unused_bits = ^{req_addr[OFF_W-1:0], tag_i[23]};

    assign hit = req_valid & valid_i & (tag_i[22:0] == req_addr[31:9]);

    // Next state and control outputs; reset masks every control output.
    always_comb begin
        state_d   = state_q;
        pmem_read = 1'b0;
        data_web  = 1'b0;
        tag_web   = 1'b0;
        valid_web = 1'b0;
        stall     = 1'b0;
        mem_resp  = 1'b0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;

        case (state_q)
            ST_CHECK: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    hit_evt  = 1'b1;
                end else if (req_valid) begin
                    stall    = 1'b1;
                    miss_evt = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pmem_read = 1'b1;
                stall     = 1'b1;
                if (pmem_resp) begin
                    state_d = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                data_web  = 1'b1;
                tag_web   = 1'b1;
                valid_web = 1'b1;
                stall     = 1'b1;
                state_d   = ST_REPLAY;
            end
            ST_REPLAY: begin
                // Arrays re-read the freshly written set on the falling edge.
                stall   = 1'b1;
                state_d = ST_CHECK;
            end
            default: begin
                state_d = ST_CHECK;
            end
        endcase

        if (rst) begin
            pmem_read = 1'b0;
            data_web  = 1'b0;
            tag_web   = 1'b0;
            valid_web = 1'b0;
            stall     = 1'b0;
            mem_resp  = 1'b0;
            hit_evt   = 1'b0;
            miss_evt  = 1'b0;
        end
    end

    // State, fetch address and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CHECK;
            pmem_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (miss_evt) begin
                pmem_addr_q <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            end
            if (hit_evt && (hit_cnt_q != CNT_MAX)) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_evt && (miss_cnt_q != CNT_MAX)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pmem_address = pmem_addr_q;
    assign hit_count    = hit_cnt_q;
    assign miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icache_miss_ctrl
// Directed bench with a scoreboard: each driven cycle pushes the hand-computed
// expected outputs into a queue; a monitor pops and compares on the falling
// edge. A second instance with 4-bit counters shares all inputs so counter
// saturation is observed alongside the main sequence.
// ----------------------------------------------------------------------------
module tb_icache_miss_ctrl;

    typedef struct packed {
        logic        pr;
        logic        dw;
        logic        tw;
        logic        vw;
        logic        st;
        logic        mr;
        logic [31:0] addr;
        logic [15:0] hc;
        logic [15:0] mc;
        logic [3:0]  h4;
        logic [3:0]  m4;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [23:0] tag_i;
    logic        valid_i;
    logic        pmem_resp;

    logic        pmem_read, data_web, tag_web, valid_web, stall, mem_resp;
    logic [31:0] pmem_address;
    logic [15:0] hit_count, miss_count;

    logic        s_pmem_read, s_data_web, s_tag_web, s_valid_web, s_stall, s_mem_resp;
    logic [31:0] s_pmem_address;
    logic [3:0]  s_hit_count, s_miss_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    icache_miss_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .tag_i(tag_i), .valid_i(valid_i), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_address(pmem_address),
        .data_web(data_web), .tag_web(tag_web), .valid_web(valid_web),
        .stall(stall), .mem_resp(mem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_miss_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .tag_i(tag_i), .valid_i(valid_i), .pmem_resp(pmem_resp),
        .pmem_read(s_pmem_read), .pmem_address(s_pmem_address),
        .data_web(s_data_web), .tag_web(s_tag_web), .valid_web(s_valid_web),
        .stall(s_stall), .mem_resp(s_mem_resp),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge.
    task automatic step(input logic r, input logic rv, input logic [31:0] a,
                        input logic [23:0] t, input logic v, input logic pr);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = rv;
        req_addr  = a;
        tag_i     = t;
        valid_i   = v;
        pmem_resp = pr;
    endtask

    // Queue the expected outputs for the cycle just driven.
    task automatic expect_o(input string nm, input logic pr, input logic we,
                            input logic st, input logic mr, input logic [31:0] a,
                            input int hc, input int mc);
        exp_t e;
        e.pr   = pr;
        e.dw   = we;
        e.tw   = we;
        e.vw   = we;
        e.st   = st;
        e.mr   = mr;
        e.addr = a;
        e.hc   = 16'(hc);
        e.mc   = 16'(mc);
        e.h4   = (hc > 15) ? 4'hF : 4'(hc);
        e.m4   = (mc > 15) ? 4'hF : 4'(mc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  act;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act.pr   = pmem_read;
            act.dw   = data_web;
            act.tw   = tag_web;
            act.vw   = valid_web;
            act.st   = stall;
            act.mr   = mem_resp;
            act.addr = pmem_address;
            act.hc   = hit_count;
            act.mc   = miss_count;
            act.h4   = s_hit_count;
            act.m4   = s_miss_count;
            n_tests++;
            if (act !== e || s_mem_resp !== e.mr || s_stall !== e.st ||
                s_data_web !== e.dw || s_pmem_read !== e.pr) begin
                n_fail++;
                $display("FAIL %s: got pr=%b we=%b%b%b st=%b mr=%b addr=%h hc=%0d mc=%0d h4=%0d m4=%0d | want pr=%b we=%b st=%b mr=%b addr=%h hc=%0d mc=%0d h4=%0d m4=%0d",
                         nm, act.pr, act.dw, act.tw, act.vw, act.st, act.mr, act.addr,
                         act.hc, act.mc, act.h4, act.m4,
                         e.pr, e.dw, e.st, e.mr, e.addr, e.hc, e.mc, e.h4, e.m4);
            end
        end
    end

    localparam logic [31:0] A_COLD = 32'h0000_1A40;
    localparam logic [23:0] T_COLD = 24'h00000D;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        tag_i     = '0;
        valid_i   = 1'b0;
        pmem_resp = 1'b0;

        // Reset for two cycles, then idle.
        step(1, 0, 0, 0, 0, 0);            expect_o("rst_c0", 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);            expect_o("rst_c1", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);            expect_o("idle",   0, 0, 0, 0, 0, 0, 0);

        // Cold miss, memory answers on the third FETCH cycle.
        step(0, 1, A_COLD, 0, 0, 0);       expect_o("cold_c0_check",  0, 0, 1, 0, 0,      0, 0);
        step(0, 1, A_COLD, 0, 0, 0);       expect_o("cold_c1_fetch",  1, 0, 1, 0, A_COLD, 0, 1);
        step(0, 1, A_COLD, 0, 0, 0);       expect_o("cold_c2_fetch",  1, 0, 1, 0, A_COLD, 0, 1);
        step(0, 1, A_COLD, 0, 0, 1);       expect_o("cold_c3_fetch",  1, 0, 1, 0, A_COLD, 0, 1);
        step(0, 1, A_COLD, 0, 0, 0);       expect_o("cold_c4_alloc",  0, 1, 1, 0, A_COLD, 0, 1);
        step(0, 1, A_COLD, T_COLD, 1, 0);  expect_o("cold_c5_replay", 0, 0, 1, 0, A_COLD, 0, 1);
        step(0, 1, A_COLD, T_COLD, 1, 1);  expect_o("cold_c6_hit",    0, 0, 0, 1, A_COLD, 0, 1);
        // Stray pmem_resp outside FETCH must have no effect.
        step(0, 0, A_COLD, T_COLD, 1, 1);  expect_o("cold_after",     0, 0, 0, 0, A_COLD, 1, 1);

        // Back-to-back hits, including offset bits and an ignored tag[23].
        step(0, 1, 32'h0000_1A40, 24'h00000D, 1, 0); expect_o("b2b_0", 0, 0, 0, 1, A_COLD, 1, 1);
        step(0, 1, 32'h0000_1A44, 24'h00000D, 1, 0); expect_o("b2b_1", 0, 0, 0, 1, A_COLD, 2, 1);
        step(0, 1, 32'h0000_2000, 24'h000010, 1, 0); expect_o("b2b_2", 0, 0, 0, 1, A_COLD, 3, 1);
        step(0, 1, 32'h8000_0020, 24'h400000, 1, 0); expect_o("b2b_3", 0, 0, 0, 1, A_COLD, 4, 1);
        step(0, 1, 32'hFFFF_FFE0, 24'hFFFFFF, 1, 0); expect_o("b2b_4", 0, 0, 0, 1, A_COLD, 5, 1);
        step(0, 0, 32'hFFFF_FFE0, 24'hFFFFFF, 1, 0); expect_o("b2b_after", 0, 0, 0, 0, A_COLD, 6, 1);

        // Tag conflict with valid set, minimum-latency fill (k = 1).
        step(0, 1, 32'h0000_0400, 24'h000001, 1, 0); expect_o("conf_c0_check",  0, 0, 1, 0, A_COLD,        6, 1);
        step(0, 1, 32'h0000_0400, 24'h000001, 1, 1); expect_o("conf_c1_fetch",  1, 0, 1, 0, 32'h0000_0400, 6, 2);
        step(0, 1, 32'h0000_0400, 24'h000001, 1, 0); expect_o("conf_c2_alloc",  0, 1, 1, 0, 32'h0000_0400, 6, 2);
        step(0, 1, 32'h0000_0400, 24'h000002, 1, 0); expect_o("conf_c3_replay", 0, 0, 1, 0, 32'h0000_0400, 6, 2);
        step(0, 1, 32'h0000_0400, 24'h000002, 1, 0); expect_o("conf_c4_hit",    0, 0, 0, 1, 32'h0000_0400, 6, 2);

        // Reset in the second FETCH cycle abandons the miss.
        step(0, 1, 32'h0000_3000, 24'h000000, 1, 0); expect_o("rstf_c0_check",  0, 0, 1, 0, 32'h0000_0400, 7, 2);
        step(0, 1, 32'h0000_3000, 24'h000000, 1, 0); expect_o("rstf_c1_fetch",  1, 0, 1, 0, 32'h0000_3000, 7, 3);
        step(1, 1, 32'h0000_3000, 24'h000000, 1, 0); expect_o("rstf_c2_rst",    0, 0, 0, 0, 32'h0000_3000, 7, 3);
        step(0, 0, 32'h0000_3000, 24'h000000, 1, 1); expect_o("rstf_c3_late",   0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 32'h0000_3000, 24'h000000, 1, 0); expect_o("rstf_c4_idle",   0, 0, 0, 0, 0, 0, 0);

        // Twenty hits: 16-bit counter keeps counting, 4-bit counter sticks at 15.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, A_COLD, T_COLD, 1, 0);
            expect_o($sformatf("sat_hit_%0d", i), 0, 0, 0, 1, 0, i, 0);
        end
        step(0, 0, A_COLD, T_COLD, 1, 0); expect_o("sat_after", 0, 0, 0, 0, 0, 20, 0);

        @(negedge clk);
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
